// File: rtl/csr_mtrap_unit.sv
// csr_mtrap_unit: machine-mode CSR file with an integrated trap controller
// for a single-issue RV32 core.
//
// Optional feature: define CSR_CYCLE_EN to implement the 64-bit mcycle/mcycleh
// counter at 0xB00/0xB80. Without it those addresses are unimplemented.
//
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   raddr/rdata      combinational CSR read (read-before-write), 0 if unimplemented
//   illegal          unimplemented read address, or an op to a read-only/unimplemented waddr
//   csr_op/waddr/wdata  CSR write/set/clear request
//   exc_*            synchronous exception request, cause, PC and trap value
//   mret             mret retiring this cycle
//   int_ok           instruction boundary where an interrupt may be taken
//   irq_in           asynchronous level-sensitive interrupt lines
//   irq_pending      |(mip & mie) & mstatus.MIE
//   redirect_valid/redirect_pc  registered one-cycle PC redirect to fetch
//   mstatus_mie      current mstatus.MIE
module csr_mtrap_unit #(
    parameter int          XLEN        = 32,
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        raddr,
    output logic [XLEN-1:0]    rdata,
    output logic               illegal,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        waddr,
    input  logic [XLEN-1:0]    wdata,
    input  logic               exc_valid,
    input  logic [3:0]         exc_code,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic               mret,
    input  logic               int_ok,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_pending,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               mstatus_mie
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
`ifdef CSR_CYCLE_EN
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
`endif

    logic               mie_b_q, mie_b_d;   // mstatus.MIE
    logic               mpie_q, mpie_d;     // mstatus.MPIE
    logic [NUM_IRQ-1:0] mie_q, mie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mscratch_q, mscratch_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [31:0]        mtval_q, mtval_d;
    logic               rv_q, rv_d;
    logic [31:0]        rpc_q, rpc_d;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
`ifdef CSR_CYCLE_EN
    logic [63:0]        mcycle_q, mcycle_d;
`endif

    logic [NUM_IRQ-1:0] mip;
    logic [31:0]        mstatus_rd, mie_rd, mip_rd;

    assign mip = sync_q[SYNC_STAGES-1];

    always_comb begin
        mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_b_q, 3'b0};
        mie_rd = '0;
        mie_rd[16 +: NUM_IRQ] = mie_q;
        mip_rd = '0;
        mip_rd[16 +: NUM_IRQ] = mip;
    end

    // Returns {implemented, value} for a CSR address.
    function automatic logic [32:0] csr_read(input logic [11:0] a);
        case (a)
            A_MSTATUS:  csr_read = {1'b1, mstatus_rd};
            A_MIE:      csr_read = {1'b1, mie_rd};
            A_MTVEC:    csr_read = {1'b1, mtvec_q};
            A_MSCRATCH: csr_read = {1'b1, mscratch_q};
            A_MEPC:     csr_read = {1'b1, mepc_q};
            A_MCAUSE:   csr_read = {1'b1, mcause_q};
            A_MTVAL:    csr_read = {1'b1, mtval_q};
            A_MIP:      csr_read = {1'b1, mip_rd};
`ifdef CSR_CYCLE_EN
            A_MCYCLE:   csr_read = {1'b1, mcycle_q[31:0]};
            A_MCYCLEH:  csr_read = {1'b1, mcycle_q[63:32]};
`endif
            default:    csr_read = '0;
        endcase
    endfunction

    logic [32:0] rd_r, rd_w;
    logic        wr_ok;
    logic [31:0] wval;

    always_comb begin
        rd_r  = csr_read(raddr);
        rd_w  = csr_read(waddr);
        wr_ok = rd_w[32] && (waddr != A_MIP);
        case (csr_op)
            2'b01:   wval = wdata;
            2'b10:   wval = rd_w[31:0] | wdata;
            2'b11:   wval = rd_w[31:0] & ~wdata;
            default: wval = rd_w[31:0];
        endcase
    end

    assign rdata       = rd_r[31:0];
    assign illegal     = !rd_r[32] || ((csr_op != 2'b00) && !wr_ok);
    assign mstatus_mie = mie_b_q;

    // Lowest-numbered pending and enabled line wins.
    logic [NUM_IRQ-1:0] pend;
    logic               pend_any;
    logic [4:0]         irq_code;

    always_comb begin
        pend     = mip & mie_q;
        pend_any = 1'b0;
        irq_code = 5'd16;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !pend_any) begin
                pend_any = 1'b1;
                irq_code = 5'(16 + i);
            end
        end
    end

    assign irq_pending = pend_any && mie_b_q;

    always_comb begin
        mie_b_d    = mie_b_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        rv_d       = 1'b0;
        rpc_d      = rpc_q;
`ifdef CSR_CYCLE_EN
        mcycle_d   = mcycle_q + 64'd1;
`endif
        if (exc_valid) begin
            mepc_d   = exc_pc & ~32'h3;
            mcause_d = {28'b0, exc_code};
            mtval_d  = exc_tval;
            mpie_d   = mie_b_q;
            mie_b_d  = 1'b0;
            rv_d     = 1'b1;
            rpc_d    = mtvec_q & ~32'h3;
        end else if (mret) begin
            mie_b_d = mpie_q;
            mpie_d  = 1'b1;
            rv_d    = 1'b1;
            rpc_d   = mepc_q;
        end else if (irq_pending && int_ok && !rv_q) begin
            mepc_d   = exc_pc & ~32'h3;
            mcause_d = {1'b1, 26'b0, irq_code};
            mtval_d  = '0;
            mpie_d   = mie_b_q;
            mie_b_d  = 1'b0;
            rv_d     = 1'b1;
            rpc_d    = mtvec_q[0] ? ((mtvec_q & ~32'h3) + {25'b0, irq_code, 2'b00})
                                  : (mtvec_q & ~32'h3);
        end else if (csr_op != 2'b00 && wr_ok) begin
            case (waddr)
                A_MSTATUS: begin
                    mie_b_d = wval[3];
                    mpie_d  = wval[7];
                end
                A_MIE:      mie_d      = wval[16 +: NUM_IRQ];
                A_MTVEC:    mtvec_d    = wval & ~32'h2;
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = wval & ~32'h3;
                A_MCAUSE:   mcause_d   = wval;
                A_MTVAL:    mtval_d    = wval;
`ifdef CSR_CYCLE_EN
                // A write to either half replaces the increment for this edge.
                A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wval};
                A_MCYCLEH:  mcycle_d   = {wval, mcycle_q[31:0]};
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_b_q    <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET & ~32'h2;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            rv_q       <= 1'b0;
            rpc_q      <= '0;
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
`ifdef CSR_CYCLE_EN
            mcycle_q   <= '0;
`endif
        end else begin
            mie_b_q    <= mie_b_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            rv_q       <= rv_d;
            rpc_q      <= rpc_d;
            sync_q[0]  <= irq_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
`ifdef CSR_CYCLE_EN
            mcycle_q   <= mcycle_d;
`endif
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// tb_csr_mtrap_unit: directed plus randomized checks of csr_mtrap_unit against
// a CSR-map reference model (associative array of architectural CSR values).
module tb_csr_mtrap_unit;

    localparam int          NUM_IRQ     = 4;
    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] MTVEC_RST   = 32'h0000_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic [11:0]        raddr;
    logic [31:0]        rdata;
    logic               illegal;
    logic [1:0]         csr_op;
    logic [11:0]        waddr;
    logic [31:0]        wdata;
    logic               exc_valid;
    logic [3:0]         exc_code;
    logic [31:0]        exc_pc;
    logic [31:0]        exc_tval;
    logic               mret;
    logic               int_ok;
    logic [NUM_IRQ-1:0] irq_in;
    logic               irq_pending;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               mstatus_mie;

    csr_mtrap_unit #(
        .XLEN(32), .NUM_IRQ(NUM_IRQ), .MTVEC_RESET(MTVEC_RST), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .illegal(illegal),
        .csr_op(csr_op), .waddr(waddr), .wdata(wdata),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret(mret), .int_ok(int_ok), .irq_in(irq_in), .irq_pending(irq_pending),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mstatus_mie(mstatus_mie)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0]        m_csr [logic [11:0]];
    logic [NUM_IRQ-1:0] syncq [$];   // oldest entry is the visible mip
    logic               m_rv;
    logic [31:0]        m_rpc;

    task automatic model_reset();
        m_csr.delete();
        m_csr[12'h300] = 32'h1800;
        m_csr[12'h304] = 0;
        m_csr[12'h305] = MTVEC_RST & ~32'h2;
        m_csr[12'h340] = 0;
        m_csr[12'h341] = 0;
        m_csr[12'h342] = 0;
        m_csr[12'h343] = 0;
        syncq.delete();
        repeat (SYNC_STAGES) syncq.push_back('0);
        m_rv  = 1'b0;
        m_rpc = 0;
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        logic [31:0] r;
        r = 0;
        if (a == 12'h344) r[16 +: NUM_IRQ] = syncq[0];
        else if (m_csr.exists(a)) r = m_csr[a];
        return r;
    endfunction

    function automatic logic [31:0] warl(input logic [11:0] a, input logic [31:0] v);
        logic [31:0] mask;
        mask = 0;
        mask[16 +: NUM_IRQ] = '1;
        case (a)
            12'h300: return (v & 32'h88) | 32'h1800;
            12'h304: return v & mask;
            12'h305: return v & ~32'h2;
            12'h341: return v & ~32'h3;
            default: return v;
        endcase
    endfunction

    function automatic logic m_irq_pending();
        logic [31:0] en, st;
        logic [NUM_IRQ-1:0] p;
        en = m_csr[12'h304];
        st = m_csr[12'h300];
        p  = syncq[0] & en[16 +: NUM_IRQ];
        return (p != 0) && st[3];
    endfunction

    function automatic logic m_illegal();
        logic rd_impl;
        rd_impl = m_csr.exists(raddr) || raddr == 12'h344;
        return !rd_impl || (csr_op != 0 && !m_csr.exists(waddr));
    endfunction

    task automatic model_edge();
        logic [31:0] st, en, old, nv, base;
        logic [NUM_IRQ-1:0] p;
        int win;
        logic nrv;
        logic [31:0] nrpc;
        st  = m_csr[12'h300];
        en  = m_csr[12'h304];
        p   = syncq[0] & en[16 +: NUM_IRQ];
        win = -1;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (p[i]) win = i;
        base = m_csr[12'h305] & ~32'h3;
        nrv  = 1'b0;
        nrpc = m_rpc;
        if (exc_valid || (m_irq_pending() && int_ok && !m_rv && !mret)) begin
            m_csr[12'h300] = 32'h1800 | (st[3] ? 32'h80 : 32'h0);
            m_csr[12'h341] = exc_pc & ~32'h3;
            nrv = 1'b1;
            if (exc_valid) begin
                m_csr[12'h342] = {28'b0, exc_code};
                m_csr[12'h343] = exc_tval;
                nrpc = base;
            end else begin
                m_csr[12'h342] = 32'h8000_0000 | (16 + win);
                m_csr[12'h343] = 0;
                nrpc = m_csr[12'h305][0] ? base + 4 * (16 + win) : base;
            end
        end else if (mret) begin
            m_csr[12'h300] = 32'h1880 | (st[7] ? 32'h8 : 32'h0);
            nrv  = 1'b1;
            nrpc = m_csr[12'h341];
        end else if (csr_op != 0 && m_csr.exists(waddr)) begin
            old = m_csr[waddr];
            case (csr_op)
                2'b01:   nv = wdata;
                2'b10:   nv = old | wdata;
                default: nv = old & ~wdata;
            endcase
            m_csr[waddr] = warl(waddr, nv);
        end
        m_rv  = nrv;
        m_rpc = nrpc;
        syncq.push_back(irq_in);
        void'(syncq.pop_front());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        csr_op = 0; waddr = 0; wdata = 0;
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0;
        mret = 0; int_ok = 0;
    endtask

    // One clock: check combinational outputs, advance, check the redirect register.
    task automatic tick();
        #1;
        chk("rdata", rdata, mread(raddr));
        chk("illegal", {31'b0, illegal}, {31'b0, m_illegal()});
        chk("irq_pending", {31'b0, irq_pending}, {31'b0, m_irq_pending()});
        chk("mstatus_mie", {31'b0, mstatus_mie}, {31'b0, m_csr[12'h300][3]});
        @(posedge clk);
        model_edge();
        #1;
        chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_rv});
        if (m_rv) chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        idle();
        csr_op = op; waddr = a; wdata = d;
        tick();
        idle();
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    logic [11:0] addrs [10];

    initial begin
        addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h343, 12'h344, 12'hB00, 12'h7C0};
        rst = 1'b1; raddr = 0; irq_in = 0;
        idle();
        model_reset();
        #12;
        rst = 1'b0;

        // Reset state and unimplemented addresses
        rd_chk("rst_mstatus", 12'h300, 32'h1800);
        rd_chk("rst_mtvec", 12'h305, MTVEC_RST);
        rd_chk("unimpl_rdata", 12'h7C0, 32'h0);
        chk("unimpl_illegal", {31'b0, illegal}, 32'h1);
        rd_chk("mcycle_absent", 12'hB00, 32'h0);
        chk("mcycle_illegal", {31'b0, illegal}, 32'h1);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'h0);

        // mstatus WARL, clear, read-only mip
        raddr = 12'h300;
        csr_wr(2'b01, 12'h300, 32'hFFFF_FFFF);
        rd_chk("mstatus_warl", 12'h300, 32'h1888);
        csr_wr(2'b11, 12'h300, 32'h8);
        rd_chk("mstatus_clr", 12'h300, 32'h1880);
        csr_op = 2'b01; waddr = 12'h344; wdata = 32'hFFFF_FFFF;
        #1;
        chk("mip_wr_illegal", {31'b0, illegal}, 32'h1);
        tick();
        idle();
        rd_chk("mip_ro", 12'h344, 32'h0);

        // Synchronous exception
        csr_wr(2'b01, 12'h305, 32'h100);
        exc_valid = 1; exc_code = 4'd2; exc_pc = 32'h2003; exc_tval = 32'hDEAD;
        tick();
        idle();
        chk("exc_rv", {31'b0, redirect_valid}, 32'h1);
        chk("exc_rpc", redirect_pc, 32'h100);
        rd_chk("exc_mepc", 12'h341, 32'h2000);
        rd_chk("exc_mcause", 12'h342, 32'h2);
        rd_chk("exc_mtval", 12'h343, 32'hDEAD);
        rd_chk("exc_mstatus", 12'h300, 32'h1800);
        tick();
        chk("exc_pulse_end", {31'b0, redirect_valid}, 32'h0);

        // Vectored interrupt, lowest enabled pending line wins
        csr_wr(2'b01, 12'h305, 32'h201);
        csr_wr(2'b01, 12'h304, 32'h30000);
        csr_wr(2'b01, 12'h300, 32'h8);
        irq_in = 4'b0110; int_ok = 1; exc_pc = 32'h3006;
        for (int k = 0; k < 8 && !m_rv; k++) tick();
        idle();
        chk("irq_rv", {31'b0, redirect_valid}, 32'h1);
        chk("irq_rpc", redirect_pc, 32'h244);
        rd_chk("irq_mcause", 12'h342, 32'h8000_0011);
        rd_chk("irq_mepc", 12'h341, 32'h3004);
        rd_chk("irq_mtval", 12'h343, 32'h0);
        rd_chk("irq_mstatus", 12'h300, 32'h1880);

        // mret
        mret = 1;
        tick();
        idle();
        chk("mret_rv", {31'b0, redirect_valid}, 32'h1);
        chk("mret_rpc", redirect_pc, 32'h3004);
        rd_chk("mret_mstatus", 12'h300, 32'h1888);

        // Same-cycle priority: exception beats mret, interrupt and CSR write
        csr_wr(2'b01, 12'h340, 32'h55);
        exc_valid = 1; exc_code = 4'd5; exc_pc = 32'h4000; exc_tval = 32'h7;
        mret = 1; int_ok = 1;
        csr_op = 2'b01; waddr = 12'h340; wdata = 32'hAA;
        tick();
        idle();
        chk("prio_rpc", redirect_pc, 32'h200);
        rd_chk("prio_mcause", 12'h342, 32'h5);
        rd_chk("prio_mscratch", 12'h340, 32'h55);
        rd_chk("prio_mstatus", 12'h300, 32'h1880);

        // Asynchronous reset in the middle of a redirect pulse
        exc_valid = 1; exc_code = 4'd3; exc_pc = 32'h5000;
        tick();
        idle();
        chk("pre_rst_rv", {31'b0, redirect_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rv", {31'b0, redirect_valid}, 32'h0);
        rd_chk("async_rst_mepc", 12'h341, 32'h0);
        rd_chk("async_rst_mstatus", 12'h300, 32'h1800);
        @(negedge clk);
        rst = 1'b0;
        irq_in = 0;
        model_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            raddr     = addrs[$urandom_range(0, 9)];
            csr_op    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            waddr     = addrs[$urandom_range(0, 9)];
            wdata     = $urandom;
            exc_valid = ($urandom_range(0, 9) == 0);
            exc_code  = 4'($urandom);
            exc_pc    = $urandom;
            exc_tval  = $urandom;
            mret      = ($urandom_range(0, 9) == 0);
            int_ok    = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) irq_in = NUM_IRQ'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
